// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and default sizing shared by the FIFO write arbiter.
package fifo_arb_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, BURST = ST_BURST} state_t;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating-priority picker, first requester at or after i_rr_ptr wins.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_rr_ptr,
  output logic                    o_valid,
  output logic [$clog2(NREQ)-1:0] o_idx
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] w_j;
  assign o_valid = |i_req;
  // Scan from farthest to nearest so the candidate closest to the pointer is kept.
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_rr_ptr) + k) % NREQ);
      if (i_req[w_j]) o_idx = w_j;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*DW-1:0]      i_wdata,
  input  logic [NREQ-1:0]         i_last,
  input  logic                    i_fifo_full,
  output logic [NREQ-1:0]         o_gnt,
  output logic [NREQ-1:0]         o_ack,
  output logic                    o_fifo_wr_en,
  output logic [DW-1:0]           o_fifo_wdata,
  output logic [$clog2(NREQ)-1:0] o_owner,
  output logic                    o_busy
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  state_t        r_state, w_state_nx;
  logic [NREQ-1:0] r_gnt, w_gnt_nx;
  logic [IW-1:0] r_owner, w_owner_nx, r_rr_ptr, w_rr_nx, w_pick_idx;
  logic [BW-1:0] r_beat_cnt, w_cnt_nx;
  logic          w_pick_valid, w_ack, w_end;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  assign w_ack = (r_state == BURST) && i_req[r_owner] && !i_fifo_full;
  // A burst ends on the owner's last beat, on the beat cap, or when the owner withdraws.
  assign w_end = (r_state == BURST) && (!i_req[r_owner] ||
                 (w_ack && (i_last[r_owner] || r_beat_cnt == BW'(MAX_BURST - 1))));

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_owner_nx = r_owner;
    w_rr_nx    = r_rr_ptr;
    w_cnt_nx   = r_beat_cnt;
    if (r_state == IDLE && w_pick_valid) begin
      w_state_nx = BURST;
      w_gnt_nx   = NREQ'(1) << w_pick_idx;
      w_owner_nx = w_pick_idx;
      w_cnt_nx   = '0;
    end else if (w_end) begin
      w_state_nx = IDLE;
      w_gnt_nx   = '0;
      w_cnt_nx   = '0;
      w_rr_nx    = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    end else if (w_ack) begin
      w_cnt_nx   = r_beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_gnt      <= w_gnt_nx;
      r_owner    <= w_owner_nx;
      r_rr_ptr   <= w_rr_nx;
      r_beat_cnt <= w_cnt_nx;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_ack        = r_gnt & {NREQ{w_ack}};
  assign o_fifo_wr_en = |o_ack;
  assign o_fifo_wdata = (|r_gnt) ? i_wdata[r_owner*DW +: DW] : '0;
  assign o_owner      = r_owner;
  assign o_busy       = (r_state == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenario tests for the round-robin FIFO write arbiter.
module tb_fifo_wr_arbiter;
  logic       clk, rst_n, full, wr_en, busy;
  logic [3:0] req, last, gnt, ack;
  logic [31:0] wdata;
  logic [7:0] fdata;
  logic [1:0] owner;
  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wdata(wdata), .i_last(last),
    .i_fifo_full(full), .o_gnt(gnt), .o_ack(ack), .o_fifo_wr_en(wr_en),
    .o_fifo_wdata(fdata), .o_owner(owner), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task do_reset;
    rst_n = 1'b0; req = '0; last = '0; full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_reset;
    rst_n = 1'b0; req = 4'b1111; last = '0; full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (gnt !== 4'b0 || wr_en !== 1'b0 || busy !== 1'b0 || fdata !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc %0d gnt %b wr_en %b busy %b wdata %h expected all 0", c, gnt, wr_en, busy, fdata);
      end
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release gnt %b owner %0d busy %b expected 0001 0 1", gnt, owner, busy);
    end
  endtask

  task test_round_robin;
    logic [3:0] e;
    do_reset;
    req = 4'b1111; last = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e = 4'b0001 << (n % 4);
      @(negedge clk); #1;
      checks++;
      if (gnt !== e || ack !== e || wr_en !== 1'b1 || fdata !== 8'(8'h11 * (n % 4 + 1))) begin
        errors++;
        $display("FAIL rr_grant %0d gnt %b ack %b wr_en %b wdata %h expected %b %b 1 %h", n, gnt, ack, wr_en, fdata, e, e, 8'(8'h11 * (n % 4 + 1)));
      end
      @(negedge clk); #1;
      checks++;
      if (gnt !== 4'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL rr_bubble %0d gnt %b busy %b wr_en %b expected 0 0 0", n, gnt, busy, wr_en);
      end
    end
    req = '0; last = '0;
  endtask

  task test_burst_cap;
    int len [3];
    len = '{8, 8, 4};
    do_reset;
    req = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < len[b]; k++) begin
        @(negedge clk); #1;
        checks++;
        if (gnt !== 4'b0100 || ack !== 4'b0100 || owner !== 2'd2 || fdata !== 8'h33) begin
          errors++;
          $display("FAIL cap_beat b%0d k%0d gnt %b ack %b owner %0d wdata %h expected 0100 0100 2 33", b, k, gnt, ack, owner, fdata);
        end
      end
      if (b < 2) begin
        @(negedge clk); #1;
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL cap_bubble b%0d gnt %b busy %b expected 0 0", b, gnt, busy);
        end
      end
    end
    @(negedge clk);
    req = 4'b0000; #1;
    checks++;
    if (gnt !== 4'b0100 || ack !== 4'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL cap_drop gnt %b ack %b wr_en %b expected 0100 0000 0", gnt, ack, wr_en);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cap_end gnt %b busy %b expected 0 0", gnt, busy);
    end
  endtask

  task test_backpressure;
    do_reset;
    req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++;
      if (gnt !== 4'b0010 || ack !== 4'b0010 || owner !== 2'd1) begin
        errors++;
        $display("FAIL bp_pre k%0d gnt %b ack %b owner %0d expected 0010 0010 1", k, gnt, ack, owner);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      full = 1'b1; #1;
      checks++;
      if (gnt !== 4'b0010 || ack !== 4'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall k%0d gnt %b ack %b wr_en %b expected 0010 0000 0", k, gnt, ack, wr_en);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      full = 1'b0; #1;
      checks++;
      if (gnt !== 4'b0010 || ack !== 4'b0010 || wr_en !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume k%0d gnt %b ack %b wr_en %b expected 0010 0010 1", k, gnt, ack, wr_en);
      end
    end
    @(negedge clk);
    req = 4'b0000; #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end gnt %b busy %b expected 0 0", gnt, busy);
    end
  endtask

  task test_req_drop;
    do_reset;
    req = 4'b1000;
    @(negedge clk);
    req = 4'b1001; #1;
    checks++;
    if (gnt !== 4'b1000 || ack !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL drop_beat1 gnt %b ack %b owner %0d expected 1000 1000 3", gnt, ack, owner);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b1000 || ack !== 4'b1000) begin
      errors++;
      $display("FAIL drop_beat2 gnt %b ack %b expected 1000 1000", gnt, ack);
    end
    @(negedge clk);
    req = 4'b0011; #1;
    checks++;
    if (gnt !== 4'b1000 || ack !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_cycle gnt %b ack %b busy %b expected 1000 0000 1", gnt, ack, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle gnt %b busy %b expected 0 0", gnt, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL drop_regrant gnt %b owner %0d expected 0001 0", gnt, owner);
    end
    req = '0;
  endtask

  task test_reset_mid_burst;
    do_reset;
    req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++;
      if (gnt !== 4'b0010 || ack !== 4'b0010) begin
        errors++;
        $display("FAIL mid_beat k%0d gnt %b ack %b expected 0010 0010", k, gnt, ack);
      end
    end
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if (ack !== 4'b0010 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat3 ack %b wr_en %b expected 0010 1", ack, wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0011; #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset gnt %b busy %b wr_en %b expected 0 0 0", gnt, busy, wr_en);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL mid_regrant gnt %b owner %0d expected 0001 0", gnt, owner);
    end
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; last = '0; full = 1'b0;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    test_reset;
    test_round_robin;
    test_burst_cap;
    test_backpressure;
    test_req_drop;
    test_reset_mid_burst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter sharing one 16-entry byte FIFO's write port among NREQ requesters. Grants one requester at a time for a burst: until `last`, MAX_BURST beats, or request drop. Drives the FIFO's `wr_en` and `data_in`, and obeys the FIFO's `data_full` as backpressure. Sits directly in front of the `fifo` block; the read side is untouched.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: data width; must match FIFO `data_in`.
- `MAX_BURST`, default 8: max beats per grant, ≥1.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `req` input NREQ: per-requester request, level.
- `wdata` input NREQ*DW: requester i data at `[i*DW +: DW]`.
- `last` input NREQ: final beat of requester i's packet.
- `fifo_full` input 1: FIFO `data_full`.
- `gnt` output NREQ: registered one-hot grant, or zero.
- `ack` output NREQ: beat accepted this cycle (combinational).
- `fifo_wr_en` output 1: FIFO `wr_en`, equal to `|ack`.
- `fifo_wdata` output DW: `wdata` slice of the granted requester; 0 when no grant.
- `owner` output $clog2(NREQ): index of granted requester, registered.
- `busy` output 1: high in BURST state.

## Operation
- States: IDLE, BURST. Registers: `state`, `gnt`, `owner`, `rr_ptr`, `beat_cnt` (width $clog2(MAX_BURST)).
- Reset (`rst_n`=0 at an edge) sets state=IDLE, gnt=0, owner=0, rr_ptr=0, beat_cnt=0. Outputs then read gnt=0, ack=0, fifo_wr_en=0, fifo_wdata=0, busy=0.
- IDLE, `|req`=0: stay.
- IDLE, `|req`=1: pick the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ. Next edge: gnt=onehot(i), owner=i, beat_cnt=0, state=BURST.
- BURST: `ack[owner] = req[owner] & ~fifo_full`. All other ack bits are 0.
- Beat accepted (ack=1) without end: beat_cnt += 1.
- End conditions, evaluated each BURST cycle:
  - (a) ack=1 and last[owner]=1;
  - (b) ack=1 and beat_cnt==MAX_BURST-1;
  - (c) req[owner]=0.
- On any end condition, next edge: state=IDLE, gnt=0, beat_cnt=0, rr_ptr=(owner+1) mod NREQ.
- `fifo_full`=1 in BURST: no ack, grant held, beat_cnt unchanged. Stalls are unbounded.
- `last` is ignored on non-ack cycles. `wdata` and `last` of non-owners are ignored.
- Requests that change during BURST do not affect the owner; they are re-sampled in the next IDLE.
- Reset mid-burst: grant drops at that edge. Beats already written stay in the FIFO; the FIFO is expected to share the reset.

## Timing
- Grant latency: req rises at edge N sampling → gnt at N+1; first ack possible in cycle N+1 (combinational ack).
- Exactly one IDLE bubble cycle between consecutive bursts, even with back-to-back requests.
- Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles.
- `fifo_wr_en` and `fifo_wdata` are combinational from registered gnt/owner and inputs. No path from `fifo_full` to `gnt`.
- Requester contract: hold wdata/last stable while req=1 and ack=0.

## Structure
- Package `fifo_arb_pkg`: state encoding localparams (IDLE=0, BURST=1) and default NREQ/DW/MAX_BURST constants.
- One sub-module, `rr_pick`: combinational rotating priority picker. Inputs req and rr_ptr; outputs valid and index.
- Everything else is flat in `fifo_wr_arbiter`.

## Test plan
- Reset: hold rst_n=0 3 cycles with req=4'b1111 → gnt=0, fifo_wr_en=0, busy=0 throughout. Release → gnt=4'b0001 one cycle later.
- Round-robin: req=4'b1111 persistently, last=1 every beat → owners 0,1,2,3,0 in sequence, one beat each. Each grant is separated by one IDLE cycle.
- Burst cap: requester 2 alone, 20 beats, last never asserted, MAX_BURST=8 → bursts of 8, 8, 4 beats. The 4-beat burst ends on req drop; bubble between bursts.
- Backpressure: owner 1 streaming, fifo_full=1 for 5 cycles mid-burst → ack=0 and gnt held during those cycles. beat_cnt is unchanged; the burst resumes with the correct remaining beats.
- Request drop: owner 3 drops req after 2 beats → gnt=0 next edge, rr_ptr=0. Pending req[0] is granted the following edge.
- Reset mid-burst: rst_n=0 during owner 1's 3rd beat → gnt=0 at that edge, rr_ptr=0. After release, requester 0 (req=4'b0011) is granted first.
